// File: rtl/intseq_pkg.sv
// Shared types and constants for the interrupt/reset/BRK entry sequencer.
//   state_t : sequencer state, 3-bit, IDLE..VEC_HI encoded 0..7
//   src_t   : latched sequence source (RST, NMI, IRQ, BRK)
//   PSRC_*  : push_src codes selecting the byte pushed to the stack
//   DEF_*   : default vector addresses (low byte; high byte at +1)
package intseq_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StDummy0  = 3'd1,
        StDummy1  = 3'd2,
        StPushPch = 3'd3,
        StPushPcl = 3'd4,
        StPushP   = 3'd5,
        StVecLo   = 3'd6,
        StVecHi   = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        SRC_RST = 2'd0,
        SRC_NMI = 2'd1,
        SRC_IRQ = 2'd2,
        SRC_BRK = 2'd3
    } src_t;

    localparam logic [1:0] PSRC_NONE = 2'd0;
    localparam logic [1:0] PSRC_PCH  = 2'd1;
    localparam logic [1:0] PSRC_PCL  = 2'd2;
    localparam logic [1:0] PSRC_P    = 2'd3;

    localparam logic [15:0] DEF_NMI_VEC = 16'hFFFA;
    localparam logic [15:0] DEF_RST_VEC = 16'hFFFC;
    localparam logic [15:0] DEF_IRQ_VEC = 16'hFFFE;

endpackage

// File: rtl/interrupt_sequencer_sync_edge_det.sv
// Input synchroniser (STAGES flops, 0 = bypass) followed by a falling-edge detector.
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset; flops and edge history reset to 1
//   din    in  raw asynchronous input
//   level  out synchronised level
//   fall   out 1 for one cycle after the synchronised level goes 1 -> 0
module sync_edge_det #(
    parameter int unsigned STAGES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic fall
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign level = din;
        end else begin : g_sync
            logic [STAGES-1:0] sync_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q <= '1;
                end else begin
                    sync_q[0] <= din;
                    for (int i = 1; i < STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign level = sync_q[STAGES-1];
        end
    endgenerate

    // History resets high so an input held low through reset yields one edge on release.
    logic hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 1'b1;
        end else begin
            hist_q <= level;
        end
    end

    assign fall = hist_q & ~level;

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt/reset/BRK entry sequencer. At an instruction boundary it takes over the stack
// and vector controls and runs: 2 dummy cycles, push PCH/PCL/P, fetch vector low/high.
//   ph2          in  clock, rising edge
//   reset_b      in  asynchronous active-low reset
//   irq_b        in  level IRQ request, active low
//   nmi_b        in  NMI request, falling-edge sensitive
//   i_flag       in  interrupt-disable flag
//   sync         in  instruction boundary
//   brk_req      in  BRK decoded (valid with sync)
//   razor_error  in  hold and replay the current cycle
//   busy         out sequencer owns stack/vector controls
//   seq_state    out current state
//   mem_we       out write strobe for push cycles
//   push_src     out byte pushed: 0 none, 1 PCH, 2 PCL, 3 P
//   sp_dec       out decrement SP
//   b_flag       out B bit for the pushed P
//   vec_fetch    out address bus driven from vec_addr
//   vec_addr     out vector byte address
//   pcl_load     out load PCL from data-in
//   pch_load     out load PCH from data-in
//   set_i        out set I flag
//   nmi_ack      out NMI vector committed
module interrupt_sequencer
    import intseq_pkg::*;
#(
    parameter logic [15:0] NMI_VEC  = DEF_NMI_VEC,
    parameter logic [15:0] RST_VEC  = DEF_RST_VEC,
    parameter logic [15:0] IRQ_VEC  = DEF_IRQ_VEC,
    parameter int unsigned NMI_SYNC = 1
) (
    input  logic        ph2,
    input  logic        reset_b,
    input  logic        irq_b,
    input  logic        nmi_b,
    input  logic        i_flag,
    input  logic        sync,
    input  logic        brk_req,
    input  logic        razor_error,
    output logic        busy,
    output logic [2:0]  seq_state,
    output logic        mem_we,
    output logic [1:0]  push_src,
    output logic        sp_dec,
    output logic        b_flag,
    output logic        vec_fetch,
    output logic [15:0] vec_addr,
    output logic        pcl_load,
    output logic        pch_load,
    output logic        set_i,
    output logic        nmi_ack
);

    logic irq_s;
    logic irq_fall_unused;
    logic nmi_s_unused;
    logic nmi_fall;

    sync_edge_det #(
        .STAGES (NMI_SYNC)
    ) u_irq_sync (
        .clk   (ph2),
        .rst_n (reset_b),
        .din   (irq_b),
        .level (irq_s),
        .fall  (irq_fall_unused)
    );

    sync_edge_det #(
        .STAGES (NMI_SYNC)
    ) u_nmi_sync (
        .clk   (ph2),
        .rst_n (reset_b),
        .din   (nmi_b),
        .level (nmi_s_unused),
        .fall  (nmi_fall)
    );

    state_t state_q, state_d;
    src_t   src_q, src_d;
    logic   rst_pend_q, rst_pend_d;
    logic   nmi_pend_q, nmi_pend_d;
    logic   irq_take;

    assign irq_take = ~irq_s & ~i_flag;

    always_ff @(posedge ph2 or negedge reset_b) begin
        if (!reset_b) begin
            state_q    <= StIdle;
            src_q      <= SRC_RST;
            rst_pend_q <= 1'b1;
            nmi_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            rst_pend_q <= rst_pend_d;
            nmi_pend_q <= nmi_pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        rst_pend_d = rst_pend_q;
        // Edge capture keeps running during a razor stall.
        nmi_pend_d = nmi_pend_q | nmi_fall;
        if (!razor_error) begin
            unique case (state_q)
                StIdle: begin
                    if (rst_pend_q) begin
                        state_d = StDummy0;
                        src_d   = SRC_RST;
                    end else if (sync && (nmi_pend_q || irq_take || brk_req)) begin
                        state_d = StDummy0;
                        if (nmi_pend_q) begin
                            src_d = SRC_NMI;
                        end else if (irq_take) begin
                            src_d = SRC_IRQ;
                        end else begin
                            src_d = SRC_BRK;
                        end
                    end
                end
                StDummy0:  state_d = StDummy1;
                StDummy1:  state_d = StPushPch;
                StPushPch: state_d = StPushPcl;
                StPushPcl: state_d = StPushP;
                StPushP: begin
                    state_d = StVecLo;
                    if (src_q == SRC_RST) begin
                        rst_pend_d = 1'b0;
                    end else if (nmi_pend_q || nmi_fall) begin
                        // Vector commit to NMI (own sequence or hijack of IRQ/BRK; P is
                        // already pushed so B is unaffected). One request is consumed: an
                        // edge this cycle survives only if an older request was the one used.
                        src_d      = SRC_NMI;
                        nmi_pend_d = nmi_pend_q & nmi_fall;
                    end
                end
                StVecLo:   state_d = StVecHi;
                StVecHi:   state_d = StIdle;
                default:   state_d = StIdle;
            endcase
        end
    end

    logic [15:0] vec_base;

    always_comb begin
        unique case (src_q)
            SRC_RST: vec_base = RST_VEC;
            SRC_NMI: vec_base = NMI_VEC;
            default: vec_base = IRQ_VEC;
        endcase
    end

    always_comb begin
        mem_we    = 1'b0;
        push_src  = PSRC_NONE;
        sp_dec    = 1'b0;
        b_flag    = 1'b0;
        vec_fetch = 1'b0;
        vec_addr  = 16'h0000;
        pcl_load  = 1'b0;
        pch_load  = 1'b0;
        set_i     = 1'b0;
        nmi_ack   = 1'b0;
        unique case (state_q)
            StIdle, StDummy0, StDummy1: ;
            StPushPch: begin
                sp_dec   = 1'b1;
                push_src = PSRC_PCH;
                mem_we   = (src_q != SRC_RST);
            end
            StPushPcl: begin
                sp_dec   = 1'b1;
                push_src = PSRC_PCL;
                mem_we   = (src_q != SRC_RST);
            end
            StPushP: begin
                sp_dec   = 1'b1;
                push_src = PSRC_P;
                mem_we   = (src_q != SRC_RST);
                b_flag   = (src_q == SRC_BRK);
            end
            StVecLo: begin
                vec_fetch = 1'b1;
                vec_addr  = vec_base;
                pcl_load  = 1'b1;
                nmi_ack   = (src_q == SRC_NMI);
            end
            StVecHi: begin
                vec_fetch = 1'b1;
                vec_addr  = vec_base + 16'd1;
                pch_load  = 1'b1;
                set_i     = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy      = (state_q != StIdle);
    assign seq_state = state_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench for interrupt_sequencer: expected per-cycle outputs are queued when
// stimulus is applied and popped/compared one per clock, 1 time unit after the rising edge.
module tb_interrupt_sequencer;

    logic        ph2 = 1'b0;
    logic        reset_b = 1'b0;
    logic        irq_b = 1'b1;
    logic        nmi_b = 1'b1;
    logic        i_flag = 1'b0;
    logic        sync = 1'b0;
    logic        brk_req = 1'b0;
    logic        razor_error = 1'b0;
    logic        busy, mem_we, sp_dec, b_flag, vec_fetch, pcl_load, pch_load, set_i, nmi_ack;
    logic [2:0]  seq_state;
    logic [1:0]  push_src;
    logic [15:0] vec_addr;

    interrupt_sequencer u_dut (
        .ph2         (ph2),
        .reset_b     (reset_b),
        .irq_b       (irq_b),
        .nmi_b       (nmi_b),
        .i_flag      (i_flag),
        .sync        (sync),
        .brk_req     (brk_req),
        .razor_error (razor_error),
        .busy        (busy),
        .seq_state   (seq_state),
        .mem_we      (mem_we),
        .push_src    (push_src),
        .sp_dec      (sp_dec),
        .b_flag      (b_flag),
        .vec_fetch   (vec_fetch),
        .vec_addr    (vec_addr),
        .pcl_load    (pcl_load),
        .pch_load    (pch_load),
        .set_i       (set_i),
        .nmi_ack     (nmi_ack)
    );

    always #5 ph2 = ~ph2;

    typedef struct packed {
        logic        busy;
        logic [2:0]  st;
        logic        mem_we;
        logic [1:0]  psrc;
        logic        sp_dec;
        logic        b_flag;
        logic        vf;
        logic [15:0] va;
        logic        pcl;
        logic        pch;
        logic        set_i;
        logic        ack;
    } obs_t;

    localparam int K_RST = 0;
    localparam int K_NMI = 1;
    localparam int K_IRQ = 2;
    localparam int K_BRK = 3;

    obs_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    function automatic logic [15:0] vec_of(int k);
        if (k == K_RST) return 16'hFFFC;
        if (k == K_NMI) return 16'hFFFA;
        return 16'hFFFE;
    endfunction

    // Expected outputs for state st of a sequence started by `kind` whose vector is `vkind`.
    function automatic obs_t model(int st, int kind, int vkind);
        obs_t o;
        o      = '0;
        o.busy = (st != 0);
        o.st   = 3'(st);
        if (st >= 3 && st <= 5) begin
            o.sp_dec = 1'b1;
            o.psrc   = 2'(st - 2);
            o.mem_we = (kind != K_RST);
        end
        o.b_flag = (st == 5) && (kind == K_BRK);
        if (st == 6) begin
            o.vf  = 1'b1;
            o.va  = vec_of(vkind);
            o.pcl = 1'b1;
            o.ack = (vkind == K_NMI);
        end
        if (st == 7) begin
            o.vf    = 1'b1;
            o.va    = vec_of(vkind) + 16'd1;
            o.pch   = 1'b1;
            o.set_i = 1'b1;
        end
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.busy   = busy;
        o.st     = seq_state;
        o.mem_we = mem_we;
        o.psrc   = push_src;
        o.sp_dec = sp_dec;
        o.b_flag = b_flag;
        o.vf     = vec_fetch;
        o.va     = vec_addr;
        o.pcl    = pcl_load;
        o.pch    = pch_load;
        o.set_i  = set_i;
        o.ack    = nmi_ack;
        return o;
    endfunction

    task automatic push_seq(int kind, int vkind);
        for (int s = 1; s <= 7; s++) sb.push_back(model(s, kind, vkind));
        sb.push_back(model(0, 0, 0));
    endtask

    task automatic push_idle(int n);
        for (int k = 0; k < n; k++) sb.push_back(model(0, 0, 0));
    endtask

    task automatic test_reset();
        obs_t obs, exp;
        push_idle(2);
        for (int c = 0; c < 2; c++) begin
            @(posedge ph2); #1;
            obs = sample(); exp = sb.pop_front(); n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL reset_hold c%0d: got %h want %h", c, obs, exp);
            end
        end
        reset_b = 1'b1;
        push_seq(K_RST, K_RST);
        for (int c = 0; c < 8; c++) begin
            @(posedge ph2); #1;
            obs = sample(); exp = sb.pop_front(); n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL reset_seq c%0d: got %h want %h", c, obs, exp);
            end
        end
    endtask

    task automatic test_irq();
        obs_t obs, exp;
        irq_b = 1'b0; i_flag = 1'b0;
        push_idle(1);
        sb.push_back(model(0, 0, 0));
        @(posedge ph2); #1;
        obs = sample(); exp = sb.pop_front(); n_checks++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL irq_arm: got %h want %h", obs, exp);
        end
        // the extra idle entry covers the cycle while sync is set up
        @(posedge ph2); #1;
        obs = sample(); exp = sb.pop_front(); n_checks++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL irq_arm2: got %h want %h", obs, exp);
        end
        sync = 1'b1;
        push_seq(K_IRQ, K_IRQ);
        for (int c = 0; c < 8; c++) begin
            @(posedge ph2); #1;
            obs = sample(); exp = sb.pop_front(); n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL irq_seq c%0d: got %h want %h", c, obs, exp);
            end
            if (c == 0) sync = 1'b0;
        end
        i_flag = 1'b1; sync = 1'b1;
        push_idle(3);
        for (int c = 0; c < 3; c++) begin
            @(posedge ph2); #1;
            obs = sample(); exp = sb.pop_front(); n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL irq_masked c%0d: got %h want %h", c, obs, exp);
            end
            if (c == 0) sync = 1'b0;
        end
        irq_b = 1'b1; i_flag = 1'b0;
        push_idle(1);
        @(posedge ph2); #1;
        obs = sample(); exp = sb.pop_front(); n_checks++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL irq_release: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_brk();
        obs_t obs, exp;
        i_flag = 1'b1; brk_req = 1'b1; sync = 1'b1;
        push_seq(K_BRK, K_IRQ);
        for (int c = 0; c < 8; c++) begin
            @(posedge ph2); #1;
            obs = sample(); exp = sb.pop_front(); n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL brk_seq c%0d: got %h want %h", c, obs, exp);
            end
            if (c == 0) begin
                sync = 1'b0; brk_req = 1'b0;
            end
        end
        i_flag = 1'b0;
    endtask

    task automatic test_nmi_hijack();
        obs_t obs, exp;
        irq_b = 1'b0;
        push_idle(1);
        @(posedge ph2); #1;
        obs = sample(); exp = sb.pop_front(); n_checks++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL hijack_arm: got %h want %h", obs, exp);
        end
        sync = 1'b1;
        push_seq(K_IRQ, K_NMI);
        for (int c = 0; c < 8; c++) begin
            @(posedge ph2); #1;
            obs = sample(); exp = sb.pop_front(); n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL hijack_seq c%0d: got %h want %h", c, obs, exp);
            end
            if (c == 0) sync = 1'b0;
            if (c == 3) nmi_b = 1'b0;   // during PUSH_PCL
            if (c == 5) irq_b = 1'b1;   // released mid-sequence: no effect
        end
        // nmi_b still held low: the one edge was consumed, so sync alone starts nothing
        sync = 1'b1;
        push_idle(3);
        for (int c = 0; c < 3; c++) begin
            @(posedge ph2); #1;
            obs = sample(); exp = sb.pop_front(); n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL hijack_held c%0d: got %h want %h", c, obs, exp);
            end
            if (c == 0) sync = 1'b0;
        end
        nmi_b = 1'b1;
        push_idle(2);
        for (int c = 0; c < 2; c++) begin
            @(posedge ph2); #1;
            obs = sample(); exp = sb.pop_front(); n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL hijack_rise c%0d: got %h want %h", c, obs, exp);
            end
        end
    endtask

    task automatic test_nmi_late();
        obs_t obs, exp;
        irq_b = 1'b0;
        push_idle(1);
        @(posedge ph2); #1;
        obs = sample(); exp = sb.pop_front(); n_checks++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL late_arm: got %h want %h", obs, exp);
        end
        sync = 1'b1;
        push_seq(K_IRQ, K_IRQ);
        push_idle(1);
        for (int c = 0; c < 9; c++) begin
            @(posedge ph2); #1;
            obs = sample(); exp = sb.pop_front(); n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL late_irq c%0d: got %h want %h", c, obs, exp);
            end
            if (c == 0) sync = 1'b0;
            if (c == 5) irq_b = 1'b1;
            if (c == 6) nmi_b = 1'b0;   // during VEC_HI
        end
        sync = 1'b1;
        push_seq(K_NMI, K_NMI);
        for (int c = 0; c < 8; c++) begin
            @(posedge ph2); #1;
            obs = sample(); exp = sb.pop_front(); n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL late_nmi c%0d: got %h want %h", c, obs, exp);
            end
            if (c == 0) sync = 1'b0;
        end
        sync = 1'b1;
        push_idle(2);
        for (int c = 0; c < 2; c++) begin
            @(posedge ph2); #1;
            obs = sample(); exp = sb.pop_front(); n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL late_held c%0d: got %h want %h", c, obs, exp);
            end
            if (c == 0) sync = 1'b0;
        end
        nmi_b = 1'b1;
        push_idle(2);
        for (int c = 0; c < 2; c++) begin
            @(posedge ph2); #1;
            obs = sample(); exp = sb.pop_front(); n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL late_rise c%0d: got %h want %h", c, obs, exp);
            end
        end
    endtask

    task automatic test_razor();
        obs_t obs, exp;
        int   st_list[10] = '{1, 2, 3, 3, 3, 4, 5, 6, 7, 0};
        irq_b = 1'b0;
        push_idle(1);
        @(posedge ph2); #1;
        obs = sample(); exp = sb.pop_front(); n_checks++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL razor_arm: got %h want %h", obs, exp);
        end
        sync = 1'b1;
        for (int k = 0; k < 10; k++) sb.push_back(model(st_list[k], K_IRQ, K_IRQ));
        for (int c = 0; c < 10; c++) begin
            @(posedge ph2); #1;
            obs = sample(); exp = sb.pop_front(); n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL razor_seq c%0d: got %h want %h", c, obs, exp);
            end
            if (c == 0) sync = 1'b0;
            if (c == 2) razor_error = 1'b1;
            if (c == 4) razor_error = 1'b0;
            if (c == 5) irq_b = 1'b1;
        end
    endtask

    task automatic test_reset_mid();
        obs_t obs, exp;
        irq_b = 1'b0;
        push_idle(1);
        @(posedge ph2); #1;
        obs = sample(); exp = sb.pop_front(); n_checks++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL rmid_arm: got %h want %h", obs, exp);
        end
        sync = 1'b1;
        for (int s = 1; s <= 5; s++) sb.push_back(model(s, K_IRQ, K_IRQ));
        for (int c = 0; c < 5; c++) begin
            @(posedge ph2); #1;
            obs = sample(); exp = sb.pop_front(); n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL rmid_seq c%0d: got %h want %h", c, obs, exp);
            end
            if (c == 0) sync = 1'b0;
        end
        reset_b = 1'b0; irq_b = 1'b1;
        push_idle(2);
        #1;
        obs = sample(); exp = sb.pop_front(); n_checks++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL rmid_async: got %h want %h", obs, exp);
        end
        @(posedge ph2); #1;
        obs = sample(); exp = sb.pop_front(); n_checks++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL rmid_held: got %h want %h", obs, exp);
        end
        reset_b = 1'b1;
        push_seq(K_RST, K_RST);
        for (int c = 0; c < 8; c++) begin
            @(posedge ph2); #1;
            obs = sample(); exp = sb.pop_front(); n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL rmid_rst c%0d: got %h want %h", c, obs, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_irq();
        test_brk();
        test_nmi_hijack();
        test_nmi_late();
        test_razor();
        test_reset_mid();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL sb_drain: got %0d entries left want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
